max_min_hold: RTL and testbench

Parametrised extremum tracker and successor to max_hold. It records the maximum and minimum of a qualified sample stream over tumbling windows of programmable length, with a signed or unsigned compare mode. It also exposes the in-progress running extremes and supports a synchronous clear. It sits on the sample path of data-acquisition designs, feeding peak and trough results to downstream logging or threshold logic.

---
 rtl/max_min_hold_pkg.sv | 24 ++
 rtl/max_min_hold_extremum_update.sv | 36 +++
 rtl/max_min_hold.sv | 113 +++++++++++
 tb/tb_max_min_hold.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/max_min_hold_pkg.sv
// ============================================================================
// max_min_hold_pkg
// Shared state encoding and count-width helper for max_min_hold.
// Revision: 1.0
// ============================================================================
`default_nettype none

package max_min_hold_pkg;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      ACC   = 1'b1
   } state_t;

   // Width needed to hold 0..window_len; window_len=0 still gets one bit.
   function automatic int count_width(input int window_len);
      int w;
      w = $clog2(window_len + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/max_min_hold_extremum_update.sv
// ============================================================================
// extremum_update
// Combinational max/min update of a running pair against one new sample.
// Revision: 1.0
// ============================================================================
`default_nettype none

module extremum_update #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] cur_max,
   input  logic [DATA_WIDTH-1:0] cur_min,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  signed_mode,
   output logic [DATA_WIDTH-1:0] new_max,
   output logic [DATA_WIDTH-1:0] new_min
);

   logic data_gt;
   logic data_lt;

   always_comb begin
      if (signed_mode) begin
         data_gt = $signed(data) > $signed(cur_max);
         data_lt = $signed(data) < $signed(cur_min);
      end else begin
         data_gt = data > cur_max;
         data_lt = data < cur_min;
      end
      new_max = data_gt ? data : cur_max;
      new_min = data_lt ? data : cur_min;
   end

endmodule

`default_nettype wire

// File: rtl/max_min_hold.sv
// ============================================================================
// max_min_hold
// Tumbling-window max/min tracker with running extremes and synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module max_min_hold
   import max_min_hold_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int WINDOW_LEN  = 16,
   parameter bit SIGNED_MODE = 1'b0
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   clear,
   input  logic                                   valid,
   input  logic [DATA_WIDTH-1:0]                  data,
   output logic [DATA_WIDTH-1:0]                  run_max,
   output logic [DATA_WIDTH-1:0]                  run_min,
   output logic                                   run_empty,
   output logic [count_width(WINDOW_LEN)-1:0]     count,
   output logic [DATA_WIDTH-1:0]                  max,
   output logic [DATA_WIDTH-1:0]                  min,
   output logic                                   out_valid
);

   localparam int              CW      = count_width(WINDOW_LEN);
   localparam logic [CW-1:0]   CNT_SAT = '1;
   localparam logic [CW-1:0]   WIN_LEN = CW'(WINDOW_LEN);

   state_t                  state;
   state_t                  state_next;
   logic [DATA_WIDTH-1:0]   upd_max;
   logic [DATA_WIDTH-1:0]   upd_min;
   logic [DATA_WIDTH-1:0]   cand_max;
   logic [DATA_WIDTH-1:0]   cand_min;
   logic [CW-1:0]           cnt_inc;
   logic [CW-1:0]           cand_cnt;
   logic                    start;
   logic                    complete;

   extremum_update #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_extremum_update (
      .cur_max     (run_max),
      .cur_min     (run_min),
      .data        (data),
      .signed_mode (SIGNED_MODE),
      .new_max     (upd_max),
      .new_min     (upd_min)
   );

   // A clear alongside a sample makes that sample the first of a fresh window.
   always_comb begin
      start    = (state == EMPTY) || clear;
      cnt_inc  = (count == CNT_SAT) ? count : count + CW'(1);
      cand_max = start ? data : upd_max;
      cand_min = start ? data : upd_min;
      cand_cnt = start ? CW'(1) : cnt_inc;
      complete = valid && (WINDOW_LEN != 0) && (cand_cnt == WIN_LEN);

      state_next = state;
      if (valid) begin
         state_next = complete ? EMPTY : ACC;
      end else if (clear) begin
         state_next = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_max   <= '0;
         run_min   <= '0;
         run_empty <= 1'b1;
         count     <= '0;
         max       <= '0;
         min       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (valid) begin
            run_max <= cand_max;
            run_min <= cand_min;
            if (complete) begin
               max       <= cand_max;
               min       <= cand_min;
               out_valid <= 1'b1;
               count     <= '0;
               run_empty <= 1'b1;
            end else begin
               count     <= cand_cnt;
               run_empty <= 1'b0;
            end
         end else if (clear) begin
            count     <= '0;
            run_empty <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_max_min_hold.sv
// ============================================================================
// tb_max_min_hold
// Four configurations of max_min_hold checked against a window-queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_max_min_hold;

   localparam int N = 4;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       valid;
   logic [7:0] data;

   logic [7:0] rmax_a [N];
   logic [7:0] rmin_a [N];
   logic [7:0] mx_a   [N];
   logic [7:0] mn_a   [N];
   logic       remp_a [N];
   logic       ov_a   [N];
   logic [2:0] cnt_a  [N];
   logic [2:0] cnt0, cnt1;
   logic       cnt2, cnt3;

   int n_cmp = 0;
   int n_err = 0;
   int w0_pulses = 0;

   // Instance configs: 0: len 4 unsigned, 1: len 4 signed, 2: len 1, 3: len 0.
   function automatic int wl_of(input int i);
      case (i)
         0, 1:    return 4;
         2:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic bit sg_of(input int i);
      return (i == 1);
   endfunction

   function automatic int cmax_of(input int i);
      return (i < 2) ? 7 : 1;
   endfunction

   function automatic int sval(input logic [7:0] d, input bit s);
      return s ? int'($signed(d)) : int'({24'b0, d});
   endfunction

   max_min_hold #(.DATA_WIDTH(8), .WINDOW_LEN(4), .SIGNED_MODE(1'b0)) u_w4u (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .data(data),
      .run_max(rmax_a[0]), .run_min(rmin_a[0]), .run_empty(remp_a[0]), .count(cnt0),
      .max(mx_a[0]), .min(mn_a[0]), .out_valid(ov_a[0]));

   max_min_hold #(.DATA_WIDTH(8), .WINDOW_LEN(4), .SIGNED_MODE(1'b1)) u_w4s (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .data(data),
      .run_max(rmax_a[1]), .run_min(rmin_a[1]), .run_empty(remp_a[1]), .count(cnt1),
      .max(mx_a[1]), .min(mn_a[1]), .out_valid(ov_a[1]));

   max_min_hold #(.DATA_WIDTH(8), .WINDOW_LEN(1), .SIGNED_MODE(1'b0)) u_w1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .data(data),
      .run_max(rmax_a[2]), .run_min(rmin_a[2]), .run_empty(remp_a[2]), .count(cnt2),
      .max(mx_a[2]), .min(mn_a[2]), .out_valid(ov_a[2]));

   max_min_hold #(.DATA_WIDTH(8), .WINDOW_LEN(0), .SIGNED_MODE(1'b0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .data(data),
      .run_max(rmax_a[3]), .run_min(rmin_a[3]), .run_empty(remp_a[3]), .count(cnt3),
      .max(mx_a[3]), .min(mn_a[3]), .out_valid(ov_a[3]));

   assign cnt_a[0] = cnt0;
   assign cnt_a[1] = cnt1;
   assign cnt_a[2] = {2'b00, cnt2};
   assign cnt_a[3] = {2'b00, cnt3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: each window is the list of samples accepted since it opened.
   logic [7:0] win_q [N][$];
   logic [7:0] m_rmax [N];
   logic [7:0] m_rmin [N];
   logic [7:0] m_mx   [N];
   logic [7:0] m_mn   [N];
   logic       m_ov   [N];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < N; i++) begin
         if (!rst_n) begin
            win_q[i].delete();
            m_rmax[i] = 8'h00;
            m_rmin[i] = 8'h00;
            m_mx[i]   = 8'h00;
            m_mn[i]   = 8'h00;
            m_ov[i]   = 1'b0;
         end else begin
            m_ov[i] = 1'b0;
            if (clear) win_q[i].delete();
            if (valid) begin
               win_q[i].push_back(data);
               m_rmax[i] = win_q[i][0];
               m_rmin[i] = win_q[i][0];
               for (int k = 1; k < win_q[i].size(); k++) begin
                  if (sval(win_q[i][k], sg_of(i)) > sval(m_rmax[i], sg_of(i))) m_rmax[i] = win_q[i][k];
                  if (sval(win_q[i][k], sg_of(i)) < sval(m_rmin[i], sg_of(i))) m_rmin[i] = win_q[i][k];
               end
               if (wl_of(i) != 0 && win_q[i].size() == wl_of(i)) begin
                  m_mx[i] = m_rmax[i];
                  m_mn[i] = m_rmin[i];
                  m_ov[i] = 1'b1;
                  win_q[i].delete();
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         int sz;
         sz = win_q[i].size();
         check($sformatf("run_max[%0d]", i),   int'(rmax_a[i]), int'(m_rmax[i]));
         check($sformatf("run_min[%0d]", i),   int'(rmin_a[i]), int'(m_rmin[i]));
         check($sformatf("max[%0d]", i),       int'(mx_a[i]),   int'(m_mx[i]));
         check($sformatf("min[%0d]", i),       int'(mn_a[i]),   int'(m_mn[i]));
         check($sformatf("out_valid[%0d]", i), int'(ov_a[i]),   int'(m_ov[i]));
         check($sformatf("run_empty[%0d]", i), int'(remp_a[i]), (sz == 0) ? 1 : 0);
         check($sformatf("count[%0d]", i),     int'(cnt_a[i]),  (sz > cmax_of(i)) ? cmax_of(i) : sz);
      end
      if (ov_a[3] === 1'b1) w0_pulses++;
   end

   task automatic step(input logic v, input logic c, input logic [7:0] d);
      valid = v;
      clear = c;
      data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_run_max"},   int'(rmax_a[0]), 0);
      check({tag, "_run_min"},   int'(rmin_a[0]), 0);
      check({tag, "_max"},       int'(mx_a[0]),   0);
      check({tag, "_min"},       int'(mn_a[0]),   0);
      check({tag, "_count"},     int'(cnt_a[0]),  0);
      check({tag, "_run_empty"}, int'(remp_a[0]), 1);
      check({tag, "_out_valid"}, int'(ov_a[0]),   0);
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      clear = 1'b0;
      data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;

      // Reset asserted mid-window, between edges.
      step(1, 0, 8'h11);
      step(1, 0, 8'h22);
      check("pre_reset_run_max", int'(rmax_a[0]), 8'h22);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midreset");
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      rst_n = 1'b1;

      // Basic window.
      step(1, 0, 8'd3);
      step(1, 0, 8'd7);
      step(1, 0, 8'd1);
      step(1, 0, 8'd5);
      check("basic_max", int'(mx_a[0]), 7);
      check("basic_min", int'(mn_a[0]), 1);
      check("basic_out_valid", int'(ov_a[0]), 1);
      check("basic_count", int'(cnt_a[0]), 0);
      check("basic_run_empty", int'(remp_a[0]), 1);
      step(0, 0, 8'd0);
      check("basic_pulse_one_cycle", int'(ov_a[0]), 0);

      // Signed versus unsigned compare.
      step(1, 0, 8'h80);
      step(1, 0, 8'h7F);
      step(1, 0, 8'h00);
      step(1, 0, 8'hFF);
      check("signed_max",   int'(mx_a[1]), 8'h7F);
      check("signed_min",   int'(mn_a[1]), 8'h80);
      check("unsigned_max", int'(mx_a[0]), 8'hFF);
      check("unsigned_min", int'(mn_a[0]), 8'h00);

      // Valid gaps.
      step(1, 0, 8'd2);
      step(0, 0, 8'd0);
      step(0, 0, 8'd0);
      step(1, 0, 8'd9);
      step(0, 0, 8'd0);
      step(1, 0, 8'd4);
      check("gaps_no_early_pulse", int'(ov_a[0]), 0);
      step(1, 0, 8'd6);
      check("gaps_out_valid", int'(ov_a[0]), 1);
      check("gaps_max", int'(mx_a[0]), 9);
      check("gaps_min", int'(mn_a[0]), 2);

      // Clear with a sample restarts the window; results held.
      step(1, 0, 8'd9);
      step(1, 0, 8'd2);
      step(1, 1, 8'd4);
      check("clear_count", int'(cnt_a[0]), 1);
      check("clear_max_held", int'(mx_a[0]), 9);
      check("clear_min_held", int'(mn_a[0]), 2);
      check("clear_no_pulse", int'(ov_a[0]), 0);
      step(1, 0, 8'd6);
      step(1, 0, 8'd8);
      step(1, 0, 8'd1);
      check("clear_out_valid", int'(ov_a[0]), 1);
      check("clear_max", int'(mx_a[0]), 8);
      check("clear_min", int'(mn_a[0]), 1);

      // Window length 1.
      step(1, 0, 8'd5);
      check("w1_ov_a", int'(ov_a[2]), 1);
      check("w1_max_a", int'(mx_a[2]), 5);
      check("w1_min_a", int'(mn_a[2]), 5);
      step(1, 0, 8'd3);
      check("w1_ov_b", int'(ov_a[2]), 1);
      check("w1_max_b", int'(mx_a[2]), 3);
      check("w1_min_b", int'(mn_a[2]), 3);

      // Randomized traffic; infinite-hold instance sees well over 100 samples.
      step(0, 1, 8'd0);
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
              ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
              8'($urandom));
      end
      step(0, 0, 8'd0);
      @(negedge clk);
      check("w0_never_pulses", w0_pulses, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
